// File: rtl/fxcs_pkg.sv
// Shared types and helpers for the fxcs arbiter slice.
// Holds the FSM state enum, an index encoder and the target-width helper.
package fxcs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int targetWidth(input int width);
    return $clog2(width);
  endfunction

  // OR-encode the set bit position; vectors are at most 64 bits wide.
  function automatic int onehotToIndex(
    input logic [63:0] vec,
    input int          width
  );
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < width && vec[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fxcs.sv
// fxcs: find the set bit of vec whose index is XOR-closest to target.
// Ports: target (TL bits), vec (WIDTH) in; pick (onehot or zero) out.
module fxcs
  import fxcs_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int ABSTRACT_MODEL = 0
) (
  input  logic [targetWidth(WIDTH)-1:0] target,
  input  logic [WIDTH-1:0]              vec,
  output logic [WIDTH-1:0]              pick
);

  localparam int TL = targetWidth(WIDTH);

  // i ^ target is a bijection, so the closest set bit is always unique.
  if (ABSTRACT_MODEL != 0) begin : g_scan
    logic [TL-1:0] best;
    logic          found;
    always_comb begin
      best  = '0;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i] && (!found || (TL'(i) ^ target) < best)) begin
          best  = TL'(i) ^ target;
          found = 1'b1;
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        pick[i] = found && vec[i] && ((TL'(i) ^ target) == best);
      end
    end
  end else begin : g_pair
    always_comb begin
      pick = '0;
      for (int i = 0; i < WIDTH; i++) begin
        pick[i] = vec[i];
        for (int j = 0; j < WIDTH; j++) begin
          if (j != i && vec[j] &&
              (TL'(j) ^ target) < (TL'(i) ^ target))
            pick[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fxcs_arbiter.sv
// Registered work-conserving arbiter; fxcs pick against a rotating target.
// Ports: i_clk, i_rstn, i_req, i_release in; o_gnt, o_gntValid, o_gntIdx,
// o_target, o_timeout out. Hold-limit timeout built with FXCS_ARBITER_TIMEOUT_EN.
module fxcs_arbiter
  import fxcs_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int ABSTRACT_MODEL = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [WIDTH-1:0]              i_req,
  input  logic                          i_release,
  output logic [WIDTH-1:0]              o_gnt,
  output logic                          o_gntValid,
  output logic [targetWidth(WIDTH)-1:0] o_gntIdx,
  output logic [targetWidth(WIDTH)-1:0] o_target,
  output logic                          o_timeout
);

  localparam int TL = targetWidth(WIDTH);

  if (WIDTH < 2 || MAX_HOLD < 2) begin : g_bad_param
    $error("fxcs_arbiter: WIDTH and MAX_HOLD must be >= 2");
  end

  state_t        state;
  logic          held;
  logic          tmo_hit;
  logic          fin;
  logic [TL-1:0] next_tgt;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] pick;
  logic [TL-1:0] pick_idx;

  assign held = |(i_req & o_gnt);
  assign fin  = (state == BUSY) &&
                (i_release || !held || tmo_hit);

  // Leaving grantee is masked so priority really moves on.
  assign cand     = (state == IDLE) ? i_req : (i_req & ~o_gnt);
  assign next_tgt = fin ? o_target + 1'b1 : o_target;
  assign pick_idx = TL'(onehotToIndex(64'(pick), WIDTH));

  fxcs #(
    .WIDTH          (WIDTH),
    .ABSTRACT_MODEL (ABSTRACT_MODEL)
  ) u_fxcs (
    .target (next_tgt),
    .vec    (cand),
    .pick   (pick)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      o_gnt      <= '0;
      o_gntValid <= 1'b0;
      o_gntIdx   <= '0;
      o_target   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|pick) begin
            o_gnt      <= pick;
            o_gntValid <= 1'b1;
            o_gntIdx   <= pick_idx;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (fin) begin
            o_target <= o_target + 1'b1;
            if (|pick) begin
              o_gnt      <= pick;
              o_gntValid <= 1'b1;
              o_gntIdx   <= pick_idx;
            end else begin
              o_gnt      <= '0;
              o_gntValid <= 1'b0;
              o_gntIdx   <= '0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FXCS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] cnt;

  // Release on the limit cycle wins over the forced end.
  assign tmo_hit = (state == BUSY) &&
                   (cnt == CW'(MAX_HOLD - 1)) &&
                   !i_release;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= tmo_hit;
      if (state == IDLE || fin) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: doc/fxcs_arbiter.md
Name: fxcs_arbiter

Overview:
Registered, work-conserving arbiter that shares one resource among WIDTH requesters. Each grant decision uses fxcs (find XOR-closest set) with an internal rotating target, so priority changes after every completed grant. The block sits between requesting agents and a shared resource, such as a bus port or memory bank. It holds one onehot grant until the grantee releases it.

Parameters:
WIDTH, 4, number of requesters; must be 2 or more.
ABSTRACT_MODEL, 0, passed unchanged to the fxcs instance.
MAX_HOLD, 16, grant-hold limit in cycles; used only when the timeout feature is compiled in; must be 2 or more.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rstn  input  1  reset; asynchronous, active-low.
i_req  input  WIDTH  request vector, one bit per requester; level-sensitive.
i_release  input  1  the current grantee has finished; sampled only in BUSY.
o_gnt  output  WIDTH  registered onehot grant, or all zeros.
o_gntValid  output  1  registered; equals |o_gnt.
o_gntIdx  output  $clog2(WIDTH)  registered binary index of the set o_gnt bit; 0 when idle.
o_target  output  $clog2(WIDTH)  current rotating target register.
o_timeout  output  1  one-cycle pulse on a forced release; tied 0 without the feature.

Behaviour:
- Reset (async, i_rstn=0):
  - state=IDLE, o_gnt=0, o_gntValid=0, o_gntIdx=0, o_target=0, hold counter=0, o_timeout=0.
  - Reset asserted mid-grant clears the grant immediately, with no clock edge needed.
- TL = $clog2(WIDTH). The target register is TL bits and wraps modulo 2^TL. Target values that index padding bits (above WIDTH-1) are legal.
- One combinational fxcs instance computes `pick = fxcs(nextTarget, candidates)`.
- State IDLE:
  - candidates = i_req; nextTarget = o_target.
  - If pick != 0: o_gnt <= pick, o_gntIdx <= index(pick), go to BUSY.
  - Request-to-grant latency is 1 cycle. With no request, stay in IDLE and hold all outputs.
- State BUSY, end of grant: a grant ends when any of these holds:
  - i_release=1;
  - the grantee's i_req bit is 0 (abandon);
  - forced timeout (feature only).
- BUSY, on end of grant:
  - o_target <= o_target + 1 (wraps).
  - candidates = i_req & ~o_gnt; nextTarget = o_target + 1. The previous grantee is excluded for this decision even if it is still requesting.
  - If pick != 0: grant pick on the next cycle (back-to-back grant, no idle bubble) and stay in BUSY.
  - Else: o_gnt <= 0, o_gntIdx <= 0, go to IDLE.
- BUSY, no end of grant: hold o_gnt, o_gntIdx and o_target unchanged. Changes to other i_req bits are ignored.
- i_release in IDLE has no effect.
- A grant is never issued to a requester whose i_req bit was 0 on the deciding edge.
- o_gnt is always onehot or zero. Padding bits never appear on any output.

Optional Feature:
FXCS_ARBITER_TIMEOUT_EN
- Defined:
  - A hold counter of $clog2(MAX_HOLD+1) bits is cleared on every new grant and increments each BUSY cycle without an end of grant.
  - When the counter equals MAX_HOLD-1 and no release occurs, that cycle is a forced end of grant, and o_timeout pulses 1 on the next cycle.
  - If a release and a timeout coincide, the release wins and o_timeout stays 0.
- Undefined: no counter is built; o_timeout is constant 0; a grant is held indefinitely.

Decomposition:
- Shared package fxcs_pkg holds:
  - the state enum (IDLE=1'b0, BUSY=1'b1);
  - a function onehotToIndex(vector, width);
  - a function targetWidth(width), which returns $clog2(width).
- The fxcs module is reused as the single sub-module instance; no new sub-module.

Test Plan:
1. WIDTH=4, after reset, i_req=4'b0110 held. o_gnt=0010 and o_gntIdx=1 one cycle later. Pulse i_release: o_target=1, o_gnt=0100 the next cycle, no bubble.
2. o_target=2, IDLE, i_req=4'b1011. Grant is 1000, because XOR distance for index 3 is 1, the minimum.
3. Grant 0001 held, then i_req[0] drops without i_release, other requests 0. Next cycle: o_gnt=0, o_gntValid=0, state IDLE, o_target incremented by 1.
4. WIDTH=5, o_target=7 (padding), i_req=5'b10000. Grant 10000 with o_gntIdx=4. Assert i_rstn=0 mid-grant: o_gnt=0 asynchronously, o_target=0.
5. With FXCS_ARBITER_TIMEOUT_EN, MAX_HOLD=4, i_req=4'b0011 constant, no release.
   - Grant 0001 for exactly 4 cycles, then o_gnt=0010 and o_timeout=1 for one cycle.
   - Repeat with i_release on the 4th cycle: o_timeout stays 0.
6. i_release=1 while IDLE and i_req=0. No output changes, o_target unchanged.
